mux_rr_arbiter: RTL and testbench

// - Round-robin arbiter that shares one DW-bit output channel among INS requesters.
// - Built around a generic N:1 select: the arbiter computes the select index, registers the chosen word and offers it downstream with valid/ready.
// - Sits between several producers and a single consumer (bus, FIFO, serializer).
//

---
 rtl/mux_rr_arbiter_if.sv | 42 ++++
 rtl/mux_rr_arbiter.sv | 117 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and its requesters/consumer.
// With ARB_LOCK_EN defined, a per-requester lock vector is added after out_ready.
interface mux_rr_arbiter_if #(
    parameter int INS = 8,
    parameter int DW  = 8
);
    localparam int SW = $clog2(INS);

    logic [INS-1:0]    req;
    logic [INS*DW-1:0] din;
    logic [INS-1:0]    gnt;
    logic [SW-1:0]     sel;
    logic              out_valid;
    logic              out_ready;
`ifdef ARB_LOCK_EN
    logic [INS-1:0]    lock;
`endif
    logic [DW-1:0]     dout;
    logic              busy;

`ifdef ARB_LOCK_EN
    modport master (
        output req, din, out_ready, lock,
        input  gnt, sel, out_valid, dout, busy
    );

    modport slave (
        input  req, din, out_ready, lock,
        output gnt, sel, out_valid, dout, busy
    );
`else
    modport master (
        output req, din, out_ready,
        input  gnt, sel, out_valid, dout, busy
    );

    modport slave (
        input  req, din, out_ready,
        output gnt, sel, out_valid, dout, busy
    );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter with a registered valid/ready output word.
// Optional burst locking of the round-robin pointer is enabled by the ARB_LOCK_EN macro.
module mux_rr_arbiter #(
    parameter int INS = 8,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              reset,
    mux_rr_arbiter_if.slave   bus
);

    localparam int              SW    = $clog2(INS);
    localparam logic [SW-1:0]   LAST  = SW'(INS - 1);
    localparam logic [SW:0]     INS_W = (SW + 1)'(INS);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         r_state;
    logic [SW-1:0]  r_ptr;
    logic [SW-1:0]  r_sel;
    logic [DW-1:0]  r_dout;
    logic           r_valid;
    logic           r_busy;
    logic [INS-1:0] r_gnt;

    logic [INS-1:0] w_rot;
    logic           w_found;
    logic [SW-1:0]  w_off;
    logic [SW:0]    w_sum;
    logic [SW-1:0]  w_pick;
    logic [DW-1:0]  w_word;
    logic [INS-1:0] w_sel_oh;
    logic [SW-1:0]  w_ptr_next;
    logic           w_hold_ptr;

    // Rotate req so bit k is requester (ptr+k) mod INS; the lowest set bit wins.
    assign w_rot = INS'({bus.req, bus.req} >> r_ptr);

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = INS - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = SW'(k);
            end
        end
    end

    assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_pick = (w_sum >= INS_W) ? SW'(w_sum - INS_W) : w_sum[SW-1:0];

    always_comb begin
        w_word = '0;
        for (int k = 0; k < INS; k++) begin
            if (w_pick == SW'(k)) begin
                w_word = bus.din[k*DW +: DW];
            end
        end
    end

    assign w_sel_oh   = {{(INS-1){1'b0}}, 1'b1} << r_sel;
    assign w_ptr_next = (r_sel == LAST) ? '0 : r_sel + 1'b1;

`ifdef ARB_LOCK_EN
    assign w_hold_ptr = |(bus.lock & w_sel_oh);
`else
    assign w_hold_ptr = 1'b0;
`endif

    // Arbitration happens only in IDLE; GRANT freezes sel/dout until the consumer takes the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_gnt   <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_pick;
                        r_dout  <= w_word;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (r_valid && bus.out_ready) begin
                        r_gnt   <= w_sel_oh;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                        if (!w_hold_ptr) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_valid;
    assign bus.dout      = r_dout;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter (INS=4, DW=8) against a behavioural model.
// Build with ARB_LOCK_EN defined to also exercise the lock/burst scenario.
module tb_mux_rr_arbiter;

    localparam int INS = 4;
    localparam int DW  = 8;

    logic clk;
    logic reset;

    int checks   = 0;
    int failures = 0;

    mux_rr_arbiter_if #(.INS(INS), .DW(DW)) bus ();

    mux_rr_arbiter #(.INS(INS), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pointer as an integer, first active requester found by modular search.
    int         m_ptr;
    int         m_sel;
    int         m_idx;
    bit         m_found;
    logic       m_valid;
    logic       m_busy;
    logic [3:0] m_gnt;
    logic [7:0] m_dout;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ptr   = 0;
            m_sel   = 0;
            m_valid = 1'b0;
            m_busy  = 1'b0;
            m_gnt   = 4'b0000;
            m_dout  = 8'h00;
        end else begin
            m_gnt = 4'b0000;
            if (!m_busy) begin
                m_found = 1'b0;
                for (int k = 0; k < INS; k++) begin
                    m_idx = (m_ptr + k) % INS;
                    if (!m_found && bus.req[m_idx]) begin
                        m_found = 1'b1;
                        m_sel   = m_idx;
                    end
                end
                if (m_found) begin
                    m_dout  = bus.din[m_sel*DW +: DW];
                    m_valid = 1'b1;
                    m_busy  = 1'b1;
                end
            end else if (bus.out_ready) begin
                m_gnt   = 4'b0001 << m_sel;
                m_valid = 1'b0;
                m_busy  = 1'b0;
`ifdef ARB_LOCK_EN
                if (!bus.lock[m_sel]) m_ptr = (m_sel + 1) % INS;
`else
                m_ptr = (m_sel + 1) % INS;
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
        checkOutput("busy",      32'(bus.busy),      32'(m_busy));
        checkOutput("gnt",       32'(bus.gnt),       32'(m_gnt));
        checkOutput("sel",       32'(bus.sel),       32'(m_sel));
        checkOutput("dout",      32'(bus.dout),      32'(m_dout));
        checkOutput("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    end

    task automatic tick;
        @(negedge clk);
        #2;
    endtask

    task automatic clearInputs;
        bus.req       = '0;
        bus.din       = '0;
        bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        bus.lock      = '0;
`endif
    endtask

    task automatic doReset;
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    bit [3:0] pend;

    task automatic applyStimulus;
        for (int i = 0; i < INS; i++) begin
            if (pend[i] && m_gnt[i]) begin
                pend[i] = 1'($urandom_range(0, 1));
                if (pend[i]) bus.din[i*DW +: DW] = 8'($urandom);
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i] = 1'b1;
                bus.din[i*DW +: DW] = 8'($urandom);
            end
        end
        bus.req       = pend;
        bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_LOCK_EN
        bus.lock      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
`endif
    endtask

    int fair_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1;
        clearInputs();
        pend = '0;
        #1;
        checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_sel",   32'(bus.sel),       32'd0);
        checkOutput("reset_gnt",   32'(bus.gnt),       32'd0);
        doReset();

        // Single requester: word A5 from requester 1.
        bus.req = 4'b0010;
        bus.din[15:8] = 8'hA5;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("single_dout",  32'(bus.dout),      32'hA5);
        checkOutput("single_sel",   32'(bus.sel),       32'd1);
        tick();
        checkOutput("single_gnt",   32'(bus.gnt),       32'b0010);
        checkOutput("single_ptr",   32'(m_ptr),         32'd2);
        bus.req = 4'b0000;

        // Wrap and skip: ptr 2 -> sel 2, then ptr 3 wraps to 0, then 2.
        bus.req = 4'b0100;
        bus.din[23:16] = 8'h5A;
        tick();
        checkOutput("wrap_sel2", 32'(bus.sel), 32'd2);
        tick();
        checkOutput("wrap_gnt2", 32'(bus.gnt), 32'b0100);
        bus.req = 4'b0101;
        bus.din[7:0] = 8'h11;
        tick();
        checkOutput("wrap_sel0", 32'(bus.sel), 32'd0);
        tick();
        checkOutput("wrap_gnt0", 32'(bus.gnt), 32'b0001);
        tick();
        checkOutput("skip_sel2", 32'(bus.sel), 32'd2);
        tick();
        bus.req = 4'b0000;

        // Backpressure: hold GRANT for 10 cycles.
        bus.out_ready = 1'b0;
        bus.req = 4'b0001;
        bus.din[7:0] = 8'h3C;
        tick();
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_dout",  32'(bus.dout),      32'h3C);
            checkOutput("bp_gnt",   32'(bus.gnt),       32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_release_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = 4'b0000;

        // Reset asserted mid-GRANT drops the word immediately.
        bus.out_ready = 1'b0;
        bus.req = 4'b0010;
        bus.din[15:8] = 8'h77;
        tick();
        checkOutput("midrst_pre_valid", 32'(bus.out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_sel",   32'(bus.sel),       32'd0);
        checkOutput("midrst_dout",  32'(bus.dout),      32'd0);
        checkOutput("midrst_gnt",   32'(bus.gnt),       32'd0);
        tick();
        reset = 1'b0;
        bus.req = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("postrst_sel", 32'(bus.sel), 32'd2);
        tick();
        bus.req = 4'b0000;

        // Fairness: all requesters active, grants must rotate.
        doReset();
        bus.req = 4'b1111;
        bus.din = 32'h44332211;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            checkOutput("fair_sel", 32'(bus.sel), 32'(fair_seq[g]));
            tick();
            checkOutput("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << fair_seq[g]));
            bus.din[fair_seq[g]*DW +: DW] = 8'($urandom);
        end
        bus.req = 4'b0000;

`ifdef ARB_LOCK_EN
        // Lock keeps requester 0 on top until its lock bit clears.
        doReset();
        bus.req = 4'b0011;
        bus.lock = 4'b0001;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            checkOutput("lock_sel0", 32'(bus.sel), 32'd0);
            if (g == 2) bus.lock = 4'b0000;
            tick();
            checkOutput("lock_gnt0", 32'(bus.gnt), 32'b0001);
        end
        tick();
        checkOutput("unlock_sel1", 32'(bus.sel), 32'd1);
        tick();
        bus.req = 4'b0000;
`endif

        // Randomized traffic under the requester hold rule.
        doReset();
        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
